// File: rtl/bcounter_reader.sv
// B-side address sequencer and read initiator for the A/B counter pair.
// Build option: BCOUNTER_SKIP_COLLISION_EN skips reads where A equals B.
module bcounter_reader #(
  parameter int B_MAX      = 8,
  parameter int NUM_PASSES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] addressAcounter,
  output logic [3:0] addressBcounter,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_count,
  output logic [7:0] skip_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    ADV,
    FIN
  } state_t;

  localparam logic [3:0] BLAST = 4'(B_MAX);
  localparam logic [8:0] NPASS = 9'(NUM_PASSES);

  state_t     state_q, state_d;
  logic [3:0] b_q, b_d;
  logic       valid_q, valid_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] sc_q, sc_d;
  logic       done_q, done_d;

  logic [8:0] pc_inc;
  logic [7:0] pc_sat;
  logic [7:0] sc_sat;
  logic       collide;

  assign pc_inc = {1'b0, pc_q} + 9'd1;
  assign pc_sat = (pc_q == 8'hFF) ? 8'hFF : pc_inc[7:0];
  assign sc_sat = (sc_q == 8'hFF) ? 8'hFF : sc_q + 8'd1;

`ifdef BCOUNTER_SKIP_COLLISION_EN
  assign collide = (addressAcounter == b_q);
`else
  assign collide = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      pc_q    <= '0;
      sc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    sc_d    = sc_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          b_d     = '0;
          pc_d    = '0;
          sc_d    = '0;
        end
      end
      LOAD: begin
        if (collide) begin
          sc_d    = sc_sat;
          state_d = ADV;
        end else begin
          // A is free-running: this is the only point it is sampled
          addr_d  = {addressAcounter, b_q};
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (valid_q && rd_ready) begin
          valid_d = 1'b0;
          state_d = ADV;
        end
      end
      ADV: begin
        if (b_q == BLAST) begin
          b_d  = '0;
          pc_d = pc_sat;
          if (pc_inc == NPASS) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          b_d     = b_q + 4'd1;
          state_d = LOAD;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign addressBcounter = b_q;
  assign rd_valid        = valid_q;
  assign rd_addr         = addr_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign pass_count      = pc_q;
  assign skip_count      = sc_q;

endmodule

// File: tb/tb_bcounter_reader.sv
// Randomised bench for bcounter_reader: default and small-sweep instances
// compared each cycle against a step-count model.
module tb_bcounter_reader;

`ifdef BCOUNTER_SKIP_COLLISION_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam int PH_LOAD = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_ADV  = 2;
  localparam int PH_FIN  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rd_ready = 1'b0;
  logic [3:0] a_val = 4'd0;

  logic [3:0] b0, b1;
  logic       v0, v1;
  logic [7:0] addr0, addr1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic [7:0] pc0, pc1;
  logic [7:0] sc0, sc1;

  int checks = 0;
  int errors = 0;

  int         a_mode = 1;
  logic [3:0] a_const = 4'd15;

  int NB[2] = '{9, 4};
  int NP[2] = '{4, 2};

  bit         m_act[2];
  int         m_phase[2];
  int         m_step[2];
  int         m_skip[2];
  int         m_hs[2];
  bit         m_valid[2];
  logic [7:0] m_addr[2];

  int dcnt[2];
  bit prev_done[2];

  bcounter_reader dut (
    .clk(clk), .reset(reset), .start(start),
    .addressAcounter(a_val), .addressBcounter(b0),
    .rd_valid(v0), .rd_ready(rd_ready), .rd_addr(addr0),
    .busy(busy0), .done(done0),
    .pass_count(pc0), .skip_count(sc0)
  );

  bcounter_reader #(.B_MAX(3), .NUM_PASSES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .addressAcounter(a_val), .addressBcounter(b1),
    .rd_valid(v1), .rd_ready(rd_ready), .rd_addr(addr1),
    .busy(busy1), .done(done1),
    .pass_count(pc1), .skip_count(sc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // A counter stand-in: counting, constant or random
  always @(negedge clk) begin
    case (a_mode)
      0: a_val = a_val + 4'd1;
      1: a_val = a_const;
      default: a_val = 4'($urandom_range(0, 15));
    endcase
  end

  // Reference: run progress is a step count; B and passes follow by division
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_phase[i] = PH_LOAD; m_step[i] = 0;
        m_skip[i] = 0; m_hs[i] = 0; m_valid[i] = 0; m_addr[i] = 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int bcur;
        bcur = m_step[i] % NB[i];
        if (!m_act[i]) begin
          if (start) begin
            m_act[i] = 1; m_phase[i] = PH_LOAD;
            m_step[i] = 0; m_skip[i] = 0; m_hs[i] = 0;
          end
        end else begin
          case (m_phase[i])
            PH_LOAD: begin
              if (SKIP && a_val == 4'(bcur)) begin
                if (m_skip[i] < 255) m_skip[i]++;
                m_phase[i] = PH_ADV;
              end else begin
                m_addr[i] = {a_val, 4'(bcur)};
                m_valid[i] = 1;
                m_phase[i] = PH_REQ;
              end
            end
            PH_REQ: begin
              if (rd_ready) begin
                m_valid[i] = 0; m_hs[i]++; m_phase[i] = PH_ADV;
              end
            end
            PH_ADV: begin
              m_step[i]++;
              m_phase[i] = (m_step[i] == NP[i] * NB[i]) ? PH_FIN : PH_LOAD;
            end
            default: begin
              m_act[i] = 0; m_phase[i] = PH_LOAD;
            end
          endcase
        end
      end
    end
  end

  task automatic cmp(input int i, input logic [3:0] b, input logic v,
                     input logic [7:0] ad, input logic bz, input logic dn,
                     input logic [7:0] pc, input logic [7:0] sc);
    int pexp;
    pexp = m_step[i] / NB[i];
    if (pexp > 255) pexp = 255;
    chk($sformatf("u%0d.B", i), b, m_step[i] % NB[i]);
    chk($sformatf("u%0d.rd_valid", i), v, m_valid[i]);
    chk($sformatf("u%0d.rd_addr", i), ad, m_addr[i]);
    chk($sformatf("u%0d.busy", i), bz, m_act[i]);
    chk($sformatf("u%0d.done", i), dn, m_act[i] && m_phase[i] == PH_FIN);
    chk($sformatf("u%0d.pass_count", i), pc, pexp);
    chk($sformatf("u%0d.skip_count", i), sc, m_skip[i]);
    if (prev_done[i]) begin
      chk($sformatf("u%0d.done_width", i), dn, 0);
      chk($sformatf("u%0d.busy_after_done", i), bz, 0);
    end
    if (dn) dcnt[i]++;
    prev_done[i] = dn;
  endtask

  always @(negedge clk) begin
    cmp(0, b0, v0, addr0, busy0, done0, pc0, sc0);
    cmp(1, b1, v1, addr1, busy1, done1, pc1, sc1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input bit rnd);
    bit ok;
    ok = 0;
    for (int k = 0; k < limit && !ok; k++) begin
      if (rnd) rd_ready = 1'($urandom_range(0, 1));
      tick();
      if (!busy0 && !busy1) ok = 1;
    end
    chk("idle_timeout", ok, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int sb, sa;
    bit ok;
    logic [7:0] hold_addr;
    logic [3:0] hold_a;
    #1 reset = 1'b0;
    repeat (3) tick();
    chk("rst.B", b0, 0);
    chk("rst.rd_valid", v0, 0);
    chk("rst.busy", busy0, 0);
    chk("rst.done", done0, 0);
    chk("rst.pass", pc0, 0);
    chk("rst.skip", sc0, 0);
    reset = 1'b1;
    repeat (3) tick();
    chk("idle.busy", busy0, 0);
    chk("idle.rd_addr", addr0, 0);

    // basic run, no collisions possible with A=15
    a_mode = 1; a_const = 4'd15; rd_ready = 1'b1;
    dcnt[0] = 0; dcnt[1] = 0;
    pulse_start();
    chk("lat.valid_c1", v0, 0);
    tick();
    chk("lat.valid_c2", v0, 1);
    chk("lat.addr", addr0, 8'hF0);
    wait_idle(300, 0);
    chk("basic.hs", m_hs[0], 36);
    chk("basic.pass", pc0, 4);
    chk("basic.done_cnt", dcnt[0], 1);
    chk("wrap.hs", m_hs[1], 8);
    chk("wrap.pass", pc1, 2);

    // backpressure with a moving A
    a_mode = 0; rd_ready = 1'b0;
    pulse_start();
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (v0) ok = 1; else tick();
    end
    chk("bp.valid_seen", ok, 1);
    hold_addr = addr0; hold_a = a_val; sb = b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp.valid_held", v0, 1);
      chk("bp.addr_held", addr0, hold_addr);
    end
    chk("bp.a_moved", a_val == hold_a, 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("bp.valid_drop", v0, 0);
    chk("bp.b_still", b0, sb);
    tick();
    chk("bp.b_next", b0, (sb + 1) % 9);
    wait_idle(3000, 1);
    chk("bp.pass", pc0, 4);

    // random A, random ready, stray starts
    a_mode = 2;
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      ok = 0;
      for (int k = 0; k < 3000 && !ok; k++) begin
        rd_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
        tick();
        start = 1'b0;
        if (!busy0) ok = 1;
      end
      chk("rnd.finished", ok, 1);
      tick();
      sa = m_hs[0] + m_skip[0];
      if (!busy0) chk("rnd.steps", sa, 36);
    end
    wait_idle(1000, 1);

    // mid-run reset while stalled at B=5
    a_mode = 1; a_const = 4'd15; rd_ready = 1'b1;
    pulse_start();
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (b0 == 4'd5 && v0) begin
        ok = 1; rd_ready = 1'b0;
      end else tick();
    end
    chk("mr.reached_b5", ok, 1);
    sa = dcnt[0];
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mr.valid", v0, 0);
    chk("mr.B", b0, 0);
    chk("mr.addr", addr0, 0);
    chk("mr.busy", busy0, 0);
    chk("mr.pass", pc0, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mr.no_done", dcnt[0], sa);
    rd_ready = 1'b1;
    pulse_start();
    wait_idle(300, 0);
    chk("mr.rerun_hs", m_hs[0], 36);
    chk("mr.rerun_pass", pc0, 4);

    // constant A=2 collides with B=2 once per pass
    a_const = 4'd2;
    tick();
    sa = dcnt[0];
    pulse_start();
    wait_idle(300, 0);
    chk("col.done", dcnt[0], sa + 1);
    chk("col.hs", m_hs[0], SKIP ? 32 : 36);
    chk("col.skip", sc0, SKIP ? 4 : 0);
    chk("col.hs_small", m_hs[1], SKIP ? 6 : 8);
    chk("col.skip_small", sc1, SKIP ? 2 : 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
